addsub_seq_nbit: RTL and testbench

//  Parametrised, multi-cycle signed add/subtract unit. Processes WIDTH-bit operands one

---
 rtl/addsub_seq_nbit_pkg.sv | 23 ++
 rtl/addsub_seq_nbit_slice.sv | 24 ++
 rtl/addsub_seq_nbit.sv | 158 +++++++++++++++
 tb/tb_addsub_seq_nbit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_seq_nbit_pkg.sv
// Shared definitions for the sequential slice-serial add/subtract unit.
// Holds the FSM state encoding and a constant-foldable log2 helper.
package addsub_seq_nbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Ceiling log2, usable in localparam expressions.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/addsub_seq_nbit_slice.sv
// Combinational SLICE-bit ripple adder; also exposes the carry into its top bit
// so the parent can form signed overflow on the final slice.
module addsub_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             c_in,
    output logic [SLICE-1:0] sum,
    output logic             c_out,
    output logic             c_msb
);

    logic [SLICE:0] full;

    always_comb begin
        full  = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, c_in};
        sum   = full[SLICE-1:0];
        c_out = full[SLICE];
        // Top-bit sum = a ^ b ^ carry-in, so the carry-in is recovered from it.
        c_msb = full[SLICE-1] ^ a[SLICE-1] ^ b[SLICE-1];
    end

endmodule

// File: rtl/addsub_seq_nbit.sv
// Multi-cycle signed add/subtract: one SLICE-bit ripple slice per clock with a
// registered inter-slice carry, optional saturation and NZV flags.
module addsub_seq_nbit
    import addsub_seq_nbit_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int SLICE  = 4,
    parameter int SAT_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic             sat,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Ovfl,
    output logic             Zero,
    output logic             Neg
);

    localparam int N  = WIDTH / SLICE;
    localparam int CW = (N > 1) ? clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t                   state;
    state_t                   state_nxt;
    logic                     accept;
    logic [CW-1:0]            cnt;
    logic                     carry;
    logic signed [WIDTH-1:0]  a_r;
    logic signed [WIDTH-1:0]  b_r;
    logic                     sat_r;
    logic signed [WIDTH-1:0]  sum_r;
    logic                     ovfl_r;
    logic                     zero_r;
    logic                     neg_r;

    int                       base;
    logic [SLICE-1:0]         sl_a;
    logic [SLICE-1:0]         sl_b;
    logic [SLICE-1:0]         sl_sum;
    logic                     sl_cout;
    logic                     sl_cmsb;
    logic signed [WIDTH-1:0]  sum_upd;
    logic signed [WIDTH-1:0]  res_final;
    logic                     ovf_final;

    // Clamp value selected by the sign of the first operand.
    function automatic logic signed [WIDTH-1:0] sat_value(input logic a_sign);
        return a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    endfunction

    function automatic logic do_saturate(input logic sat_req, input logic ovf);
        return (SAT_EN != 0) && sat_req && ovf;
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (cnt == LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Slice operand mux: the single adder is steered by the slice counter.
    always_comb begin
        base = int'(cnt) * SLICE;
        sl_a = a_r[base +: SLICE];
        sl_b = b_r[base +: SLICE];
    end

    addsub_slice #(.SLICE(SLICE)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (carry),
        .sum   (sl_sum),
        .c_out (sl_cout),
        .c_msb (sl_cmsb)
    );

    always_comb begin
        sum_upd               = sum_r;
        sum_upd[base +: SLICE] = sl_sum;
        ovf_final             = sl_cmsb ^ sl_cout;
        res_final             = do_saturate(sat_r, ovf_final) ? sat_value(a_r[WIDTH-1]) : sum_upd;
    end

    // Stage boundary: FSM, slice counter, carry and result/flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            sum_r  <= '0;
            ovfl_r <= 1'b0;
            zero_r <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt   <= '0;
                carry <= sub;
            end else if (state == ST_RUN) begin
                carry <= sl_cout;
                if (cnt == LAST) begin
                    cnt    <= '0;
                    sum_r  <= res_final;
                    ovfl_r <= ovf_final;
                    zero_r <= (res_final == '0);
                    neg_r  <= res_final[WIDTH-1];
                end else begin
                    cnt   <= cnt + CW'(1);
                    sum_r <= sum_upd;
                end
            end
        end
    end

    // Operand capture; subtraction folds into B inversion plus carry-in.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r   <= A;
            b_r   <= B ^ {WIDTH{sub}};
            sat_r <= sat;
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign Sum  = sum_r;
    assign Ovfl = ovfl_r;
    assign Zero = zero_r;
    assign Neg  = neg_r;

endmodule

// File: tb/tb_addsub_seq_nbit.sv
// Scoreboard bench for addsub_seq_nbit: directed corner cases plus randomized
// operations checked against an integer-arithmetic reference model.
module tb_addsub_seq_nbit;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             sub;
    logic             sat;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Sum;
    logic             Ovfl;
    logic             Zero;
    logic             Neg;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             ovfl;
        logic             zero;
        logic             neg;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks    = 0;
    int   errors    = 0;
    int   done_seen = 0;

    addsub_seq_nbit #(.WIDTH(WIDTH), .SLICE(SLICE), .SAT_EN(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sub   (sub),
        .sat   (sat),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .Ovfl  (Ovfl),
        .Zero  (Zero),
        .Neg   (Neg)
    );

    always #5 clk = ~clk;

    // Reference: exact integer result, overflow when outside the 16-bit signed range.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic s, input logic st);
        int   ia;
        int   ib;
        int   r;
        bit   ov;
        exp_t e;
        ia = int'($signed(a));
        ib = int'($signed(b));
        r  = s ? (ia - ib) : (ia + ib);
        ov = (r > 32767) || (r < -32768);
        if (ov && st) e.sum = (r > 0) ? 16'h7FFF : 16'h8000;
        else          e.sum = r[WIDTH-1:0];
        e.ovfl = ov;
        e.zero = (e.sum == '0);
        e.neg  = e.sum[WIDTH-1];
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                mon_e = sb_q.pop_front();
                check("mon_sum",  {16'h0, Sum}, {16'h0, mon_e.sum});
                check("mon_ovfl", {31'h0, Ovfl}, {31'h0, mon_e.ovfl});
                check("mon_zero", {31'h0, Zero}, {31'h0, mon_e.zero});
                check("mon_neg",  {31'h0, Neg},  {31'h0, mon_e.neg});
            end
        end
    end

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input logic st, input bit push);
        @(negedge clk);
        A     = a;
        B     = b;
        sub   = s;
        sat   = st;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        A     = WIDTH'($urandom);
        B     = WIDTH'($urandom);
        sub   = 1'($urandom);
        sat   = 1'($urandom);
        if (push) sb_q.push_back(model(a, b, s, st));
    endtask

    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        while (!done && cyc < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d required<40", cyc);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int               cyc;
        int               bc;
        int               seen;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic [WIDTH-1:0] edges [4];

        edges[0] = 16'h7FFF;
        edges[1] = 16'h8000;
        edges[2] = 16'hFFFF;
        edges[3] = 16'h0000;
        rst = 1'b1; start = 1'b0; sub = 1'b0; sat = 1'b0; A = '0; B = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 0);
        check("rst_done", {31'h0, done}, 0);
        check("rst_sum",  {16'h0, Sum},  0);
        check("rst_flags", {29'h0, Ovfl, Zero, Neg}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Plain add: latency and busy length.
        issue(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
        wait_done(cyc, bc);
        check("t1_latency", cyc, 4);
        check("t1_busy_cycles", bc, 4);
        check("t1_sum", {16'h0, Sum}, 32'h2345);

        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        wait_done(cyc, bc);
        check("t2_wrap_sum", {16'h0, Sum}, 32'h8000);
        check("t2_wrap_flags", {30'h0, Ovfl, Neg}, 32'h3);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1);
        wait_done(cyc, bc);
        check("t2_sat_sum", {16'h0, Sum}, 32'h7FFF);
        check("t2_sat_flags", {30'h0, Ovfl, Neg}, 32'h2);

        issue(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
        wait_done(cyc, bc);
        check("t3_negsat_sum", {16'h0, Sum}, 32'h8000);
        check("t3_negsat_flags", {30'h0, Ovfl, Neg}, 32'h3);
        issue(16'h1234, 16'h1234, 1'b1, 1'b0, 1'b1);
        wait_done(cyc, bc);
        check("t3_zero_sum", {16'h0, Sum}, 0);
        check("t3_zero_flags", {30'h0, Zero, Ovfl}, 32'h2);

        // start during RUN is ignored; start in DONE is accepted back-to-back.
        issue(16'h0F0F, 16'h0101, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        issue(16'h5555, 16'h2222, 1'b1, 1'b0, 1'b0);
        wait_done(cyc, bc);
        check("t4_ignored_start_sum", {16'h0, Sum}, 32'h1010);
        issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        check("t4_b2b_busy", {30'h0, busy, done}, 32'h2);
        wait_done(cyc, bc);
        check("t4_b2b_latency", cyc, 4);
        check("t4_b2b_sum", {16'h0, Sum}, 0);
        check("t4_b2b_flags", {30'h0, Zero, Ovfl}, 32'h2);

        // Reset mid-operation aborts with no done.
        issue(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_abort_ctrl", {30'h0, busy, done}, 0);
        check("t5_abort_sum", {16'h0, Sum}, 0);
        check("t5_abort_flags", {29'h0, Ovfl, Zero, Neg}, 0);
        @(negedge clk);
        rst  = 1'b0;
        seen = done_seen;
        repeat (8) @(posedge clk);
        #1;
        check("t5_no_done", done_seen, seen);
        issue(16'h4000, 16'h1001, 1'b1, 1'b0, 1'b1);
        wait_done(cyc, bc);
        check("t5_fresh_latency", cyc, 4);
        check("t5_fresh_sum", {16'h0, Sum}, 32'h2FFF);

        for (int i = 0; i < 1000; i++) begin
            ra = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 3)] : WIDTH'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? edges[$urandom_range(0, 3)] : WIDTH'($urandom);
            issue(ra, rb, 1'($urandom), 1'($urandom), 1'b1);
            wait_done(cyc, bc);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end

        repeat (4) @(posedge clk);
        #1;
        check("sb_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
